// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with combinational write-through
// read ports and a per-register busy scoreboard for RAW/WAW hazard detection.
// Register 0 is hardwired to zero and never becomes busy.
module regfile_sb #(
    parameter int width     = 32,
    parameter int addrWidth = 5,
    parameter int depth     = 2**addrWidth,
    parameter int numRead   = 2
) (
    input  logic                         Clk,
    input  logic                         ResetN,
    input  logic [numRead*addrWidth-1:0] ReadRegister,
    output logic [numRead*width-1:0]     ReadData,
    output logic [numRead-1:0]           ReadBusy,
    input  logic [addrWidth-1:0]         WriteRegister,
    input  logic [width-1:0]             WriteData,
    input  logic                         RegWrite,
    input  logic                         IssueValid,
    input  logic [addrWidth-1:0]         IssueRegister,
    output logic                         IssueStall,
    output logic [addrWidth:0]           BusyCount
);

    logic [width-1:0]   r_regs [depth];
    logic [depth-1:0]   r_busy;
    logic [addrWidth:0] r_busy_cnt;

    logic w_wb_en;
    logic w_issue_bypass;
    logic w_issue_stall;
    logic w_issue_acc;
    logic w_cnt_inc;
    logic w_cnt_dec;

    // A writeback to register 0 is discarded entirely
    assign w_wb_en        = RegWrite && (WriteRegister != '0);
    // A writeback landing this cycle on the issue target resolves its WAW hazard
    assign w_issue_bypass = RegWrite && (WriteRegister == IssueRegister);
    assign w_issue_stall  = IssueValid && (IssueRegister != '0) &&
                            r_busy[IssueRegister] && !w_issue_bypass;
    assign w_issue_acc    = IssueValid && (IssueRegister != '0) && !w_issue_stall;

    // Count moves only when a busy bit actually flips: an accepted issue on an
    // already-busy register (retired this cycle) leaves the bit at 1, and a
    // writeback that coincides with an issue to the same register does not clear.
    assign w_cnt_inc = w_issue_acc && !r_busy[IssueRegister];
    assign w_cnt_dec = w_wb_en && r_busy[WriteRegister] &&
                       !(w_issue_acc && (IssueRegister == WriteRegister));

    assign IssueStall = w_issue_stall;
    assign BusyCount  = r_busy_cnt;

    // Read ports: zero register, write-through bypass, else stored value
    for (genvar gi = 0; gi < numRead; gi++) begin : g_rd
        logic [addrWidth-1:0] w_raddr;
        logic                 w_hit_wb;

        assign w_raddr  = ReadRegister[gi*addrWidth +: addrWidth];
        assign w_hit_wb = RegWrite && (WriteRegister == w_raddr);

        assign ReadData[gi*width +: width] = (w_raddr == '0) ? '0 :
                                             w_hit_wb        ? WriteData :
                                                               r_regs[w_raddr];
        assign ReadBusy[gi] = (w_raddr != '0) && r_busy[w_raddr] && !w_hit_wb;
    end

    // Register storage: cleared on reset, written on non-zero writeback
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int k = 0; k < depth; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[WriteRegister] <= WriteData;
        end
    end

    // Scoreboard: writeback clears, accepted issue sets (issue wins on collision)
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_busy <= '0;
        end else begin
            if (w_wb_en) begin
                r_busy[WriteRegister] <= 1'b0;
            end
            if (w_issue_acc) begin
                r_busy[IssueRegister] <= 1'b1;
            end
        end
    end

    // Busy population count tracked incrementally alongside the busy bits
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_busy_cnt <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            r_busy_cnt <= r_busy_cnt + (addrWidth+1)'(1);
        end else if (w_cnt_dec && !w_cnt_inc) begin
            r_busy_cnt <= r_busy_cnt - (addrWidth+1)'(1);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checking of regfile_sb against a
// behavioural array model of the register contents and busy set.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 32;
    localparam int NR = 2;

    logic              Clk = 1'b0;
    logic              ResetN;
    logic [NR*AW-1:0]  ReadRegister;
    logic [NR*W-1:0]   ReadData;
    logic [NR-1:0]     ReadBusy;
    logic [AW-1:0]     WriteRegister;
    logic [W-1:0]      WriteData;
    logic              RegWrite;
    logic              IssueValid;
    logic [AW-1:0]     IssueRegister;
    logic              IssueStall;
    logic [AW:0]       BusyCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_regs [D];
    bit           m_busy [D];

    always #5 Clk = ~Clk;

    regfile_sb #(
        .width    (W),
        .addrWidth(AW),
        .depth    (D),
        .numRead  (NR)
    ) dut (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .ReadRegister (ReadRegister),
        .ReadData     (ReadData),
        .ReadBusy     (ReadBusy),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .IssueValid   (IssueValid),
        .IssueRegister(IssueRegister),
        .IssueStall   (IssueStall),
        .BusyCount    (BusyCount)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < D; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    function automatic bit m_wb_hits(input logic [AW-1:0] a);
        return RegWrite && (WriteRegister == a);
    endfunction

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (m_wb_hits(a)) return WriteData;
        return m_regs[a];
    endfunction

    function automatic bit m_rbusy(input logic [AW-1:0] a);
        return (a != 0) && m_busy[a] && !m_wb_hits(a);
    endfunction

    function automatic bit m_stall();
        return IssueValid && (IssueRegister != 0) && m_busy[IssueRegister] &&
               !m_wb_hits(IssueRegister);
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < D; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            logic [AW-1:0] a;
            a = ReadRegister[i*AW +: AW];
            check_eq($sformatf("%s_rdata%0d", tag, i), 64'(ReadData[i*W +: W]), 64'(m_read(a)));
            check_eq($sformatf("%s_rbusy%0d", tag, i), 64'(ReadBusy[i]), 64'(m_rbusy(a)));
        end
        check_eq({tag, "_stall"}, 64'(IssueStall), 64'(m_stall()));
        check_eq({tag, "_count"}, 64'(BusyCount), 64'(m_count()));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [W-1:0] wd,
                         input logic iv, input logic [AW-1:0] ir,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        IssueValid    = iv;
        IssueRegister = ir;
        ReadRegister  = {r1, r0};
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        drive(1'b0, '0, '0, 1'b0, '0, r0, r1);
    endtask

    // Check combinational outputs, take one clock edge, advance the model.
    task automatic step(input string tag);
        bit acc;
        #1;
        check_all(tag);
        @(posedge Clk);
        acc = IssueValid && (IssueRegister != 0) && !m_stall();
        if (RegWrite && WriteRegister != 0) begin
            m_regs[WriteRegister] = WriteData;
            m_busy[WriteRegister] = 1'b0;
        end
        if (acc) m_busy[IssueRegister] = 1'b1;
        @(negedge Clk);
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, D-1));
    endfunction

    task automatic random_run(input int n);
        for (int c = 0; c < n; c++) begin
            drive(1'($urandom_range(0, 1)), pick(), $urandom, 1'($urandom_range(0, 1)),
                  pick(), pick(), pick());
            step("rnd");
        end
    endtask

    initial begin
        m_clear();
        ResetN = 1'b0;
        idle(5'd0, 5'd5);
        repeat (2) @(negedge Clk);
        #1;
        check_all("reset");
        check_eq("reset_count_zero", 64'(BusyCount), 64'd0);
        ResetN = 1'b1;
        @(negedge Clk);

        // Basic write then read on every port
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        step("wr5");
        idle(5'd5, 5'd5);
        #1;
        check_eq("rd5_port0", 64'(ReadData[0 +: W]), 64'h0000_0000_DEAD_BEEF);
        check_eq("rd5_port1", 64'(ReadData[W +: W]), 64'h0000_0000_DEAD_BEEF);
        step("rd5");

        // Register 0 ignores writes
        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd0);
        step("wr0");
        idle(5'd0, 5'd0);
        #1;
        check_eq("rd0_zero", 64'(ReadData[0 +: W]), 64'd0);
        step("rd0");

        // Write-through bypass
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd0);
        #1;
        check_eq("bypass_r7", 64'(ReadData[0 +: W]), 64'h0000_0000_A5A5_A5A5);
        step("bypass");

        // Scoreboard set / WAW stall / clear
        drive(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd3, 5'd3);
        step("iss3");
        idle(5'd3, 5'd0);
        #1;
        check_eq("busy_r3", 64'(ReadBusy[0]), 64'd1);
        check_eq("count_one", 64'(BusyCount), 64'd1);
        step("busy3");
        drive(1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd3, 5'd0);
        #1;
        check_eq("waw_stall", 64'(IssueStall), 64'd1);
        step("reiss3");
        idle(5'd3, 5'd0);
        #1;
        check_eq("count_still_one", 64'(BusyCount), 64'd1);
        drive(1'b1, 5'd3, 32'h0BAD_CAFE, 1'b0, 5'd0, 5'd3, 5'd0);
        step("wb3");
        idle(5'd3, 5'd0);
        #1;
        check_eq("count_cleared", 64'(BusyCount), 64'd0);
        check_eq("busy_r3_clear", 64'(ReadBusy[0]), 64'd0);
        step("after_wb3");

        // Same-cycle writeback and issue on a busy register
        drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        step("iss9");
        drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd9, 5'd9, 5'd0);
        #1;
        check_eq("simul_no_stall", 64'(IssueStall), 64'd0);
        step("simul9");
        idle(5'd9, 5'd0);
        #1;
        check_eq("simul_busy", 64'(ReadBusy[0]), 64'd1);
        check_eq("simul_data", 64'(ReadData[0 +: W]), 64'h0000_0000_CAFE_F00D);
        check_eq("simul_count", 64'(BusyCount), 64'd1);
        step("after_simul");
        drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 5'd9, 5'd0);
        step("wb9");

        // Fill every register, then drain
        for (int r = 1; r < D; r++) begin
            drive(1'b0, 5'd0, '0, 1'b1, AW'(r), AW'(r), AW'(r - 1));
            step("fill");
        end
        idle(5'd31, 5'd1);
        #1;
        check_eq("fill_count", 64'(BusyCount), 64'd31);
        step("full");
        for (int r = 1; r < D; r++) begin
            drive(1'b1, AW'(r), $urandom, 1'b0, 5'd0, AW'(r), AW'(r));
            step("drain");
        end
        idle(5'd1, 5'd31);
        #1;
        check_eq("drain_count", 64'(BusyCount), 64'd0);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        check_eq("iss0_no_stall", 64'(IssueStall), 64'd0);
        step("iss0");
        idle(5'd0, 5'd0);
        #1;
        check_eq("iss0_count", 64'(BusyCount), 64'd0);
        step("after_iss0");

        // Randomized traffic
        random_run(500);

        // Asynchronous reset mid-run with data and busy bits present
        drive(1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd4, 5'd0, 5'd0);
        step("pre_rst");
        drive(1'b0, 5'd0, '0, 1'b1, 5'd12, 5'd6, 5'd4);
        step("pre_rst2");
        drive(1'b0, 5'd0, '0, 1'b1, 5'd4, 5'd6, 5'd4);
        #2;
        ResetN = 1'b0;
        #1;
        m_clear();
        check_all("async_rst");
        check_eq("async_rst_rd6", 64'(ReadData[0 +: W]), 64'd0);
        check_eq("async_rst_busy4", 64'(ReadBusy[1]), 64'd0);
        check_eq("async_rst_stall", 64'(IssueStall), 64'd0);
        check_eq("async_rst_count", 64'(BusyCount), 64'd0);
        @(negedge Clk);
        ResetN = 1'b1;
        step("post_rst");
        random_run(150);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write-port register file, for the pipelined core. It provides a configurable number of combinational read ports with write-through bypass and an asynchronous active-low reset that clears every register. It also keeps a per-register scoreboard: issue sets a busy bit, writeback clears it. Issue logic uses ReadBusy and IssueStall to detect RAW and WAW hazards.

Parameters:
width, 32, data bits per register
addrWidth, 5, register address bits
depth, 2**addrWidth, number of registers; register 0 is hardwired to zero
numRead, 2, number of independent read ports (>=1)

Ports:
Clk  input  1  clock; all state updates on posedge
ResetN  input  1  asynchronous, active-low reset
ReadRegister  input  numRead*addrWidth  read addresses; port i uses bits [i*addrWidth +: addrWidth]
ReadData  output  numRead*width  read data; port i uses bits [i*width +: width]
ReadBusy  output  numRead  port i's register has a pending writeback
WriteRegister  input  addrWidth  writeback address
WriteData  input  width  writeback data
RegWrite  input  1  writeback enable
IssueValid  input  1  request to reserve destination IssueRegister
IssueRegister  input  addrWidth  destination being issued
IssueStall  output  1  issue refused this cycle (WAW hazard)
BusyCount  output  addrWidth+1  number of busy registers

Behaviour:
- Reset (ResetN=0, asynchronous): all registers = 0, all busy bits = 0, BusyCount = 0. ReadData follows the cleared contents. ReadBusy = 0 and IssueStall = 0 while reset is held.
- Reset released mid-operation: no pending busy bits survive; the first posedge after deassertion behaves normally.
- Write: at posedge, if RegWrite && WriteRegister != 0, registers[WriteRegister] <= WriteData. Writes to register 0 are ignored.
- Read (combinational, zero latency):
  - ReadRegister == 0 -> ReadData = 0.
  - Else if RegWrite && WriteRegister == ReadRegister -> ReadData = WriteData (write-through bypass).
  - Else -> ReadData = stored value.
- ReadBusy[i]: busy[ReadRegister_i] && !(RegWrite && WriteRegister == ReadRegister_i). Always 0 for register 0.
- IssueStall: IssueValid && IssueRegister != 0 && busy[IssueRegister] && !(RegWrite && WriteRegister == IssueRegister).
- Issue accepted when IssueValid && !IssueStall && IssueRegister != 0. Accepted issue sets busy[IssueRegister] at posedge.
- Writeback: RegWrite && WriteRegister != 0 clears busy[WriteRegister] at posedge. Writing a non-busy register is legal and leaves busy at 0.
- Same-cycle accepted issue and writeback to the same register: busy ends at 1 (issue wins). Data is still written.
- Issue to register 0: no effect, never stalls.
- BusyCount: registered population count of busy bits, updated at the same posedge as the busy bits. Net change per cycle is -1, 0 or +1. Max value is depth-1.
- No X propagation: unwritten registers read 0 after reset.

Test Plan:
- Reset: drive ResetN=0 mid-run with registers written and busy set -> every ReadData = 0, ReadBusy = 0, BusyCount = 0 immediately, before any clock edge.
- Write/read: write 0xDEADBEEF to r5, then read r5 on all numRead ports -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
- Bypass: RegWrite=1, WriteRegister=7, WriteData=0xA5A5A5A5, ReadRegister0=7 in the same cycle -> ReadData0 = 0xA5A5A5A5 before the edge.
- Scoreboard: issue r3 -> ReadBusy=1, BusyCount=1. Issue r3 again -> IssueStall=1, BusyCount stays 1. Writeback r3 -> busy cleared, BusyCount=0.
- Simultaneous: r9 busy, writeback r9 and issue r9 in the same cycle -> IssueStall=0, busy[r9]=1 after the edge, data updated, BusyCount unchanged.
- Fill: issue r1..r31 on consecutive cycles -> BusyCount=31. Then writeback all 31 -> BusyCount=0. Issue r0 -> no stall, BusyCount stays 0.
